stage_type_scanner: RTL and testbench
=====================================

# stage_type_scanner

Sequencer that time-shares one opcode-to-ASCII type decoder among all pipeline stages. On a snapshot strobe it captures the opcode of every stage, feeds them one at a time to the shared decoder, and streams the resulting type characters, followed by a newline, to the text/debug display writer over a valid/ready handshake. It sits between the pipeline stage registers and the character sink of the debug display.

## Interface

- NUM_STAGES, 5, number of pipeline stages scanned; stage 0 = IF … stage 4 = WB
- COL_W, $clog2(NUM_STAGES+1), width of char_col
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- snap  in  1  request to capture and print the current stage opcodes; sampled on clk
- opcodes  in  7*NUM_STAGES  packed stage opcodes; stage k at bits [7k+6:7k]
- dec_opcode  out  7  opcode presented to the shared type decoder
- dec_ascii  in  8  decoder result, combinational from dec_opcode
- char_valid  out  1  char_data/char_col valid
- char_ready  in  1  sink accepts the character
- char_data  out  8  ASCII character
- char_col  out  COL_W  column: stage index 0..NUM_STAGES-1, NUM_STAGES for newline
- busy  out  1  frame in progress (state != IDLE)
- overrun  out  1  sticky: a snap arrived while busy

## Operation

- States: IDLE, DECODE, SEND, EOL. Index register idx (COL_W bits) and snapshot registers snap_op[0..NUM_STAGES-1].
- IDLE: on snap=1, latch all opcodes into snap_op, idx<=0, go to DECODE.
- DECODE: dec_opcode = snap_op[idx]. At the clock edge: char_data<=dec_ascii, char_col<=idx, char_valid<=1, go to SEND.
- SEND: hold char_data/char_col/char_valid stable until char_valid&&char_ready.
  - Handshake with idx<NUM_STAGES-1: idx<=idx+1, char_valid<=0, go to DECODE.
  - Handshake with idx==NUM_STAGES-1: char_data<=8'h0A, char_col<=NUM_STAGES, char_valid stays 1, go to EOL.
- EOL: on handshake, char_valid<=0, go to IDLE.
- dec_opcode = 7'b0 in every state except DECODE.
- snap in any state other than IDLE is ignored and sets overrun<=1. This includes the EOL handshake cycle. overrun clears only on rst.
- opcodes changing after capture does not affect the frame in progress.
- busy is combinational from state.

## Timing

- Reset (async, immediate): state=IDLE, idx=0, snap_op all 0, char_valid=0, char_data=8'h00, char_col=0, dec_opcode=0, busy=0, overrun=0.
- Reset mid-frame abandons the frame. char_valid drops without a handshake, and no partial output resumes.
- With snap sampled at edge 0 and char_ready held 1:
  - DECODE in cycle 1.
  - First char_valid in cycle 2.
  - Stage characters in cycles 2, 4, 6, 8, 10.
  - Newline in cycle 11.
  - busy=0 from cycle 12.
  - Frame length = 2*NUM_STAGES+2 cycles.
- Backpressure: each extra cycle with char_ready=0 while valid extends the frame by one cycle. There is no bubble cycle between the last stage character and the newline.
- A snap accepted earliest in the first IDLE cycle after the EOL handshake starts a new frame.

## Test plan

- Opcodes IF..WB = 0110011, 0010011, 0000011, 0100011, 1100011, ready=1, one snap pulse -> stream "R","I","L","S","B",8'h0A with char_col 0..5. The first char_valid appears 2 cycles after snap, and the frame takes 12 cycles.
- Same frame, char_ready low for 3 cycles while "L" is valid -> char_data=8'h4C and char_col=2 stay stable for the whole stall, no character is lost or duplicated, and the frame takes 15 cycles.
- Opcodes 1101111, 1100111, 0110111, 1111111, 0000000 -> "J","I","U","X","X",8'h0A. Change opcodes one cycle after snap -> output still reflects the captured values.
- Pulse snap again in cycle 5 and again in the EOL handshake cycle -> both are ignored, only one frame is printed, and overrun=1 stays set until rst.
- Assert rst asynchronously in cycle 7 mid-frame -> char_valid, busy and all other outputs go to their reset values immediately. A new snap afterwards produces a complete, correct frame starting at col 0.
- Back-to-back snaps with snap held high continuously -> a new frame starts in each first IDLE cycle, and overrun is set by the mid-frame samples.

Source files
------------

// File: rtl/stage_type_scanner.sv
// stage_type_scanner
//   Captures every pipeline stage's opcode on a snap strobe, runs them one
//   at a time through a shared (external, combinational) type decoder and
//   streams one ASCII type character per stage plus a trailing newline to a
//   valid/ready character sink.
// Ports:
//   clk, rst         clock, async active-high reset
//   snap             capture request (accepted only when idle)
//   opcodes          packed stage opcodes, stage k at [7k+6:7k]
//   dec_opcode       opcode presented to the shared decoder (0 unless DECODE)
//   dec_ascii        decoder result for dec_opcode
//   char_valid/char_ready/char_data/char_col   character stream handshake
//   busy             frame in progress
//   overrun          sticky: snap seen while busy
module stage_type_scanner #(
  parameter int NUM_STAGES = 5,
  parameter int COL_W      = $clog2(NUM_STAGES+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    snap,
  input  logic [7*NUM_STAGES-1:0] opcodes,
  output logic [6:0]              dec_opcode,
  input  logic [7:0]              dec_ascii,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic [7:0]              char_data,
  output logic [COL_W-1:0]        char_col,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, DECODE, SEND, EOL} state_t;

  localparam logic [COL_W-1:0] LAST    = COL_W'(NUM_STAGES-1);
  localparam logic [COL_W-1:0] NL_COL  = COL_W'(NUM_STAGES);

  state_t                          state, state_nxt;
  logic [COL_W-1:0]                idx;
  logic [NUM_STAGES-1:0][6:0]      snap_op;
  logic [6:0]                      sel_op;
  logic                            hs, cap, last;

  assign hs   = char_valid && char_ready;
  assign cap  = (state == IDLE) && snap;
  assign last = (idx == LAST);
  assign busy = (state != IDLE);

  // Index mux over the snapshot; written as a compare loop so the index
  // width never has to match the (non power-of-two) stage count.
  always_comb begin
    sel_op = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      if (idx == COL_W'(k)) sel_op = snap_op[k];
  end

  assign dec_opcode = (state == DECODE) ? sel_op : 7'b0;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snap) state_nxt = DECODE;
      DECODE:  state_nxt = SEND;
      SEND:    if (hs) state_nxt = last ? EOL : DECODE;
      EOL:     if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. The packed snapshot layout matches the opcodes bus, so the
  // whole bus is captured in one assignment.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snap_op    <= '0;
      idx        <= '0;
      char_valid <= 1'b0;
      char_data  <= 8'h00;
      char_col   <= '0;
    end else begin
      case (state)
        IDLE: if (cap) begin
          snap_op <= opcodes;
          idx     <= '0;
        end
        DECODE: begin
          char_data  <= dec_ascii;
          char_col   <= idx;
          char_valid <= 1'b1;
        end
        SEND: if (hs) begin
          if (last) begin
            // Newline follows the last stage with no bubble; valid stays up.
            char_data <= 8'h0A;
            char_col  <= NL_COL;
          end else begin
            idx        <= idx + 1'b1;
            char_valid <= 1'b0;
          end
        end
        EOL: if (hs) char_valid <= 1'b0;
        default: ;
      endcase
    end

  always_ff @(posedge clk or posedge rst)
    if (rst)                         overrun <= 1'b0;
    else if (snap && state != IDLE)  overrun <= 1'b1;

endmodule

// File: tb/tb_stage_type_scanner.sv
module tb_stage_type_scanner;
  localparam int N = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          snap = 1'b0;
  logic [7*N-1:0] opcodes = '0;
  logic [6:0]    dec_opcode;
  logic [7:0]    dec_ascii;
  logic          char_valid;
  logic          char_ready = 1'b1;
  logic [7:0]    char_data;
  logic [2:0]    char_col;
  logic          busy, overrun;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] d; logic [2:0] c; } exp_t;
  exp_t q[$];

  stage_type_scanner #(.NUM_STAGES(N)) dut (
    .clk(clk), .rst(rst), .snap(snap), .opcodes(opcodes),
    .dec_opcode(dec_opcode), .dec_ascii(dec_ascii),
    .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .char_col(char_col),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference type decoder (RV32 major opcodes).
  function automatic logic [7:0] tdec(input logic [6:0] op);
    case (op)
      7'b0110011:             return "R";
      7'b0010011, 7'b1100111: return "I";
      7'b0000011:             return "L";
      7'b0100011:             return "S";
      7'b1100011:             return "B";
      7'b1101111:             return "J";
      7'b0110111, 7'b0010111: return "U";
      default:                return "X";
    endcase
  endfunction

  assign dec_ascii = tdec(dec_opcode);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_frame(input logic [7*N-1:0] ops);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.d = tdec(ops[7*k +: 7]); e.c = 3'(k); q.push_back(e);
    end
    e.d = 8'h0A; e.c = 3'(N); q.push_back(e);
  endtask

  // Scoreboard: every accepted character must be the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && char_valid && char_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra: got char %h col %0d, expected none", char_data, char_col);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_data", 32'(char_data), 32'(e.d));
        chk("sb_col",  32'(char_col),  32'(e.c));
      end
    end
  end

  // One frame: snap at edge 0, optional stall, extra snaps and opcode change.
  task automatic frame(input logic [7*N-1:0] ops, input logic [7*N-1:0] ops_after,
                       input int stall_cyc, input int stall_n, input int snap_again,
                       input bit snap_eol, input int exp_len);
    int cyc;
    push_frame(ops);
    opcodes = ops; snap = 1'b1;
    step();
    snap = 1'b0; opcodes = ops_after;
    cyc = 1;
    chk("decode_busy", 32'(busy), 1);
    chk("decode_valid", 32'(char_valid), 0);
    chk("decode_op", 32'(dec_opcode), 32'(ops[6:0]));
    while (cyc < 100) begin
      if (!busy) break;
      char_ready = !(cyc >= stall_cyc && cyc < stall_cyc + stall_n);
      snap = (cyc == snap_again) || (snap_eol && char_valid && char_col == 3'(N));
      if (cyc == 2) begin
        chk("first_valid", 32'(char_valid), 1);
        chk("first_col", 32'(char_col), 0);
      end
      if (!char_ready) begin
        chk("stall_valid", 32'(char_valid), 1);
        chk("stall_data", 32'(char_data), 32'(tdec(ops[20:14])));
        chk("stall_col", 32'(char_col), 2);
      end
      if (char_valid) chk("send_decop", 32'(dec_opcode), 0);
      step();
      cyc++;
    end
    snap = 1'b0; char_ready = 1'b1;
    chk("frame_len", 32'(cyc), 32'(exp_len));
  endtask

  localparam logic [7*N-1:0] OPS_A = {7'b1100011, 7'b0100011, 7'b0000011, 7'b0010011, 7'b0110011};
  localparam logic [7*N-1:0] OPS_B = {7'b0000000, 7'b1111111, 7'b0110111, 7'b1100111, 7'b1101111};
  localparam logic [7*N-1:0] OPS_R = {N{7'b0110011}};

  initial begin
    int cyc;
    // Reset state
    #2;
    chk("rst_valid", 32'(char_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(char_data), 0);
    chk("rst_col", 32'(char_col), 0);
    chk("rst_decop", 32'(dec_opcode), 0);
    chk("rst_overrun", 32'(overrun), 0);
    step(); rst = 1'b0; step();

    // Basic frame R I L S B \n
    frame(OPS_A, OPS_A, 0, 0, 0, 1'b0, 12);
    chk("no_overrun", 32'(overrun), 0);
    step();

    // Stall 3 cycles on "L"
    frame(OPS_A, OPS_A, 6, 3, 0, 1'b0, 15);
    step();

    // J I U X X \n with opcodes changed right after capture
    frame(OPS_B, OPS_R, 0, 0, 0, 1'b0, 12);
    chk("no_overrun2", 32'(overrun), 0);
    step();

    // Ignored snaps in cycle 5 and the EOL handshake cycle
    frame(OPS_A, OPS_A, 0, 0, 5, 1'b1, 12);
    chk("ovr_set", 32'(overrun), 1);
    step(); step();
    chk("only_one_frame", 32'(busy), 0);
    chk("ovr_sticky", 32'(overrun), 1);

    // Async reset mid-frame in cycle 7
    push_frame(OPS_A);
    opcodes = OPS_A; snap = 1'b1;
    step(); snap = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst_busy", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(char_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_data", 32'(char_data), 0);
    chk("arst_col", 32'(char_col), 0);
    chk("arst_decop", 32'(dec_opcode), 0);
    chk("arst_overrun", 32'(overrun), 0);
    q.delete();
    step(); rst = 1'b0; step();
    chk("post_rst_idle", 32'(char_valid), 0);
    frame(OPS_B, OPS_B, 0, 0, 0, 1'b0, 12);
    chk("post_rst_ovr", 32'(overrun), 0);
    step();

    // snap held high: back-to-back frames
    push_frame(OPS_A); push_frame(OPS_A);
    opcodes = OPS_A; snap = 1'b1;
    step(); cyc = 1;
    while (cyc < 12) begin step(); cyc++; end
    chk("b2b_idle_busy", 32'(busy), 0);
    chk("b2b_idle_valid", 32'(char_valid), 0);
    chk("b2b_overrun", 32'(overrun), 1);
    step(); cyc++;
    chk("b2b_restart", 32'(busy), 1);
    chk("b2b_decop", 32'(dec_opcode), 32'(OPS_A[6:0]));
    snap = 1'b0;
    while (cyc < 100) begin
      if (!busy) break;
      step(); cyc++;
    end
    chk("b2b_len", 32'(cyc), 24);

    step(); step();
    chk("sb_left", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
